data_mem_sized: RTL
===================

Name: data_mem_sized

Overview:
Parametrised, byte-addressable, big-endian data memory for the pipelined datapath MEM stage. It supports byte, half and word loads and stores, with sign or zero extension on loads. Reads are registered with a one-cycle response and a valid flag. Misaligned or out-of-range accesses raise an error pulse. Reset starts a word-per-cycle clear sequence instead of a combinational wipe of the whole array.

Parameters:
- DEPTH_BYTES, 1024: memory size in bytes; must be a power of two and >= 4.
- ADDR_W, 32: width of the address port; upper bits beyond log2(DEPTH_BYTES) are range-checked.
- CLEAR_VALUE, 32'h0000_0000: word written into every location during the clear sequence.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- memRead  in  1  load request, valid only when ready=1.
- memWrite  in  1  store request, valid only when ready=1.
- size  in  2  2'b00 byte, 2'b01 half, 2'b10 word, 2'b11 reserved.
- unsignedLoad  in  1  1 = zero-extend sub-word loads; 0 = sign-extend.
- address  in  ADDR_W  byte address; big-endian (lowest address holds the MSB).
- writeData  in  32  store data; the low 8/16/32 bits are stored by size.
- ready  out  1  1 when in IDLE; requests are ignored when 0.
- readData  out  32  load result, updated together with rvalid and held until the next load completes.
- rvalid  out  1  one-cycle pulse, the cycle after an accepted, error-free load.
- err  out  1  one-cycle pulse, the cycle after an accepted request that is rejected.

Behaviour:
- Storage: DEPTH_BYTES/4 words of 32 bits. Word index = address[log2(DEPTH_BYTES)-1:2]. Byte lane 0 = bits [31:24].
- FSM states: CLEAR, IDLE.
  - reset=1 at a posedge: go to CLEAR, clear counter <= 0, ready=0, rvalid=0, err=0, readData=0. This applies in any state, including mid-CLEAR (the counter restarts at 0).
  - CLEAR: write CLEAR_VALUE to word[counter] each cycle and increment the counter. After writing the last word, go to IDLE.
  - CLEAR lasts exactly DEPTH_BYTES/4 cycles; ready rises the cycle after the last word is written.
- Out of reset, the array contents are undefined until the first CLEAR completes. Reset must be asserted at power-up.
- IDLE: ready=1. A request is accepted at a posedge when memRead or memWrite is 1.
- Error conditions, checked combinationally on the accepted request:
  - memRead and memWrite both 1;
  - size == 2'b11;
  - half access with address[0] != 0;
  - word access with address[1:0] != 0;
  - any address bit at or above log2(DEPTH_BYTES) set (out of range).
- On an error: no array write, readData unchanged, err=1 in the next cycle, rvalid=0.
- Store: only the addressed byte lanes are written, at the same posedge the request is accepted.
  - Byte: writeData[7:0] goes to lane address[1:0].
  - Half: writeData[15:0] goes to lanes {addr, addr+1}.
  - Word: the full word is written.
- Load: the addressed word is read at acceptance, the lane is extracted and extended, and the result is registered. readData and rvalid=1 appear the next cycle (latency 1).
- Back-to-back: one request per cycle, no bubbles; ready stays 1 in IDLE.
- Store followed by load to the same address in the next cycle returns the new data (the write was committed at the earlier edge).
- Requests arriving while ready=0 are dropped: no effect, no err.

Optional Feature:
- Macro DMEM_TRACE_EN.
- Defined: each committed store prints, in simulation, the time, the byte address, the size and the merged 32-bit word after the write. Each err pulse also prints the offending address and the cause.
- Undefined: no display statements are compiled; the hardware behaviour is identical either way.

Decomposition:
- Package dmem_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD;
  - FSM state typedef {ST_CLEAR, ST_IDLE};
  - error-cause enum {E_NONE, E_BOTH, E_SIZE, E_ALIGN, E_RANGE}, used by the trace feature.
- Sub-module dmem_lane_align (combinational), used by the top level:
  - store-merge of old word + writeData + size + address[1:0] -> new word and 4-bit lane mask;
  - load-extract of word + size + address[1:0] + unsignedLoad -> 32-bit extended result.
- Top level holds the array, the FSM, the clear counter, the error check and the output registers.

Test Plan:
- Clear sequence: DEPTH_BYTES=64, reset for 1 cycle, then released -> ready=0 for exactly 16 cycles then 1; word loads of 0x0, 0x3C -> 0x00000000.
- Store then load: store word 0x11223344 @0x10, then loads:
  - byte @0x13 unsigned -> 0x00000044;
  - half @0x10 signed -> 0x00001122;
  - store byte 0x80 @0x11, then load byte @0x11 signed -> 0xFFFFFF80, unsigned -> 0x00000080, and word @0x10 -> 0x11803344.
- Alignment and range errors:
  - half @0x21 -> err pulse, no write;
  - word @0x22 -> err pulse;
  - word @DEPTH_BYTES -> err pulse, rvalid=0, readData unchanged.
- Back-to-back: store word 0xDEADBEEF @0x4 in cycle n, load word @0x4 in cycle n+1 -> rvalid and 0xDEADBEEF in cycle n+2.
- Conflict and reserved: memRead=memWrite=1 @0x8 -> err, word @0x8 unchanged; size=2'b11 -> err.
- Reset mid-clear: assert reset at clear cycle 7 of 16 -> counter restarts; ready rises exactly 16 cycles after reset is released; a store issued while ready=0 has no effect.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the sized, big-endian data memory.
// Optional simulation trace is enabled with DMEM_TRACE_EN.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_e;

    typedef enum logic [2:0] {
        E_NONE,
        E_BOTH,
        E_SIZE,
        E_ALIGN,
        E_RANGE
    } err_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Big-endian lane steering: store merge with lane mask, load extract/extend.
// Lane 0 is bits [31:24]; mask bit j covers bits [8j+7:8j].
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [31:0] st_word_o,
    output logic [3:0]  st_mask_o,
    output logic [31:0] ld_data_o
);

    logic [31:0] wrep;
    logic [7:0]  bsel;
    logic [15:0] hsel;

    always_comb begin
        wrep      = wdata_i;
        st_mask_o = 4'b0000;
        unique case (size_i)
            SZ_BYTE: begin
                wrep      = {4{wdata_i[7:0]}};
                st_mask_o = 4'b1000 >> lane_i;
            end
            SZ_HALF: begin
                wrep      = {2{wdata_i[15:0]}};
                st_mask_o = lane_i[1] ? 4'b0011 : 4'b1100;
            end
            SZ_WORD: st_mask_o = 4'b1111;
            default: st_mask_o = 4'b0000;
        endcase
    end

    always_comb begin
        st_word_o = rword_i;
        for (int j = 0; j < 4; j++) begin
            if (st_mask_o[j]) st_word_o[8*j +: 8] = wrep[8*j +: 8];
        end
    end

    always_comb begin
        unique case (lane_i)
            2'd0:    bsel = rword_i[31:24];
            2'd1:    bsel = rword_i[23:16];
            2'd2:    bsel = rword_i[15:8];
            default: bsel = rword_i[7:0];
        endcase
        hsel = lane_i[1] ? rword_i[15:0] : rword_i[31:16];
    end

    always_comb begin
        unique case (size_i)
            SZ_BYTE: ld_data_o = uns_i ? {24'h0, bsel}
                                       : {{24{bsel[7]}}, bsel};
            SZ_HALF: ld_data_o = uns_i ? {16'h0, hsel}
                                       : {{16{hsel[15]}}, hsel};
            SZ_WORD: ld_data_o = rword_i;
            default: ld_data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_mem_sized.sv
// Byte-addressable big-endian data memory with word-per-cycle clear.
// Define DMEM_TRACE_EN to print committed stores and error causes.
module data_mem_sized
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned ADDR_W      = 32,
    parameter logic [31:0] CLEAR_VALUE = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [1:0]        size,
    input  logic              unsignedLoad,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       writeData,
    output logic              ready,
    output logic [31:0]       readData,
    output logic              rvalid,
    output logic              err
);

    localparam int unsigned AW    = $clog2(DEPTH_BYTES);
    localparam int unsigned WORDS = DEPTH_BYTES / 4;
    localparam int unsigned IW    = (AW > 2) ? AW - 2 : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    logic [31:0] mem_q [WORDS];

    state_e      state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        err_q, err_d;

    logic [IW-1:0] widx;
    logic [31:0] rword;
    logic [31:0] st_word;
    logic [3:0]  st_mask;
    logic [31:0] ld_data;
    logic        accept;
    logic        range_bad;
    logic        align_bad;
    err_e        cause;
    logic        clr_we;
    logic        st_we;

    assign widx      = IW'(address >> 2);
    assign rword     = mem_q[widx];
    assign range_bad = |(address >> AW);
    assign align_bad = ((size == SZ_HALF) && address[0]) ||
                       ((size == SZ_WORD) && (address[1:0] != 2'b00));
    assign accept    = (state_q == ST_IDLE) && (memRead || memWrite);

    always_comb begin
        cause = E_NONE;
        if (memRead && memWrite)  cause = E_BOTH;
        else if (size == SZ_RSVD) cause = E_SIZE;
        else if (align_bad)       cause = E_ALIGN;
        else if (range_bad)       cause = E_RANGE;
    end

    dmem_lane_align u_align (
        .size_i    (size),
        .lane_i    (address[1:0]),
        .uns_i     (unsignedLoad),
        .wdata_i   (writeData),
        .rword_i   (rword),
        .st_word_o (st_word),
        .st_mask_o (st_mask),
        .ld_data_o (ld_data)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        clr_we   = 1'b0;
        st_we    = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (accept) begin
                    if (cause != E_NONE) begin
                        err_d = 1'b1;
                    end else if (memWrite) begin
                        st_we = 1'b1;
                    end else begin
                        rvalid_d = 1'b1;
                        rdata_d  = ld_data;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_CLEAR;
            cnt_q    <= '0;
            rdata_q  <= 32'h0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    // Array has no reset; byte-lane enables keep it RAM-inferable.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clr_we) begin
                mem_q[cnt_q] <= CLEAR_VALUE;
            end else if (st_we) begin
                for (int j = 0; j < 4; j++) begin
                    if (st_mask[j]) mem_q[widx][8*j +: 8] <= st_word[8*j +: 8];
                end
            end
        end
    end

    assign ready    = (state_q == ST_IDLE);
    assign readData = rdata_q;
    assign rvalid   = rvalid_q;
    assign err      = err_q;

`ifdef DMEM_TRACE_EN
    always @(posedge clk) begin
        if (!reset && st_we)
            $display("%0t dmem store addr=%h size=%0d word=%h",
                     $time, address, size, st_word);
        if (!reset && err_d)
            $display("%0t dmem err addr=%h cause=%s",
                     $time, address, cause.name());
    end
`endif

endmodule
